// File: rtl/tick_pkg.sv
// Shared types and constants for the market-data tick parser.
// Define TICK_PARSER_CHECKSUM_EN to append an XOR checksum byte to each message.
package tick_pkg;

    localparam logic [7:0] MSG_TYPE_ADD = 8'h41;
    localparam logic [7:0] SIDE_BUY     = 8'h42;
    localparam logic [7:0] SIDE_SELL    = 8'h53;

`ifdef TICK_PARSER_CHECKSUM_EN
    localparam int MSG_LEN = 11;

    typedef enum logic [2:0] {
        ST_TYPE  = 3'd0,
        ST_SIDE  = 3'd1,
        ST_PRICE = 3'd2,
        ST_QTY   = 3'd3,
        ST_CSUM  = 3'd4,
        ST_SKIP  = 3'd5
    } tick_state_e;
`else
    localparam int MSG_LEN = 10;

    typedef enum logic [2:0] {
        ST_TYPE  = 3'd0,
        ST_SIDE  = 3'd1,
        ST_PRICE = 3'd2,
        ST_QTY   = 3'd3,
        ST_SKIP  = 3'd5
    } tick_state_e;
`endif

endpackage

// File: rtl/tick_msg_parser.sv
// Decodes one add-order tick per UDP datagram from an AXI-Stream byte feed.
// Optional TICK_PARSER_CHECKSUM_EN adds a trailing XOR byte check before emit.
module tick_msg_parser
    import tick_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] m_tick_price,
    output logic [31:0] m_tick_qty,
    output logic        m_tick_is_buy,
    output logic        m_tick_valid,
    output logic        err_pulse,
    output logic [31:0] msg_count,
    output logic [15:0] drop_count
);

    tick_state_e state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] price_q, price_d;
    logic        side_q, side_d;
    logic [31:0] out_price_q, out_price_d;
    logic [31:0] out_qty_q, out_qty_d;
    logic        out_buy_q, out_buy_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] msg_cnt_q, msg_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
`ifdef TICK_PARSER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        beat;
    logic        last;
    logic        emit;
    logic        drop;
    logic [31:0] field;

    // The parser never stalls the stream; it only refuses bytes while held in reset.
    assign s_axis_tready = ~rst;
    assign beat          = s_axis_tvalid & s_axis_tready;
    assign last          = s_axis_tlast;
    assign field         = {shift_q[23:0], s_axis_tdata};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        price_d     = price_q;
        side_d      = side_q;
        out_price_d = out_price_q;
        out_qty_d   = out_qty_q;
        out_buy_d   = out_buy_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        msg_cnt_d   = msg_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        emit        = 1'b0;
        drop        = 1'b0;
`ifdef TICK_PARSER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        if (beat) begin
`ifdef TICK_PARSER_CHECKSUM_EN
            csum_d = csum_q ^ s_axis_tdata;
`endif
            unique case (state_q)
                ST_TYPE: begin
`ifdef TICK_PARSER_CHECKSUM_EN
                    csum_d = s_axis_tdata;
`endif
                    // A datagram ending on its first byte is short; stay in TYPE.
                    if (last) begin
                        drop = 1'b1;
                    end else if (s_axis_tdata != MSG_TYPE_ADD) begin
                        drop    = 1'b1;
                        state_d = ST_SKIP;
                    end else begin
                        state_d = ST_SIDE;
                    end
                end
                ST_SIDE: begin
                    if (last) begin
                        drop    = 1'b1;
                        state_d = ST_TYPE;
                    end else if (s_axis_tdata != SIDE_BUY && s_axis_tdata != SIDE_SELL) begin
                        drop    = 1'b1;
                        state_d = ST_SKIP;
                    end else begin
                        side_d  = (s_axis_tdata == SIDE_BUY);
                        idx_d   = 2'd0;
                        state_d = ST_PRICE;
                    end
                end
                ST_PRICE: begin
                    shift_d = field;
                    idx_d   = idx_q + 2'd1;
                    if (last) begin
                        drop    = 1'b1;
                        state_d = ST_TYPE;
                    end else if (idx_q == 2'd3) begin
                        if (field == 32'd0) begin
                            drop    = 1'b1;
                            state_d = ST_SKIP;
                        end else begin
                            price_d = field;
                            state_d = ST_QTY;
                        end
                    end
                end
                ST_QTY: begin
                    shift_d = field;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
`ifdef TICK_PARSER_CHECKSUM_EN
                        if (last) begin
                            drop    = 1'b1;
                            state_d = ST_TYPE;
                        end else begin
                            state_d = ST_CSUM;
                        end
`else
                        emit        = 1'b1;
                        out_price_d = price_q;
                        out_qty_d   = field;
                        out_buy_d   = side_q;
                        state_d     = last ? ST_TYPE : ST_SKIP;
`endif
                    end else if (last) begin
                        drop    = 1'b1;
                        state_d = ST_TYPE;
                    end
                end
`ifdef TICK_PARSER_CHECKSUM_EN
                ST_CSUM: begin
                    if (s_axis_tdata == csum_q) begin
                        emit        = 1'b1;
                        out_price_d = price_q;
                        out_qty_d   = shift_q;
                        out_buy_d   = side_q;
                    end else begin
                        drop = 1'b1;
                    end
                    state_d = last ? ST_TYPE : ST_SKIP;
                end
`endif
                ST_SKIP: begin
                    if (last) begin
                        state_d = ST_TYPE;
                    end
                end
                default: begin
                    state_d = ST_TYPE;
                end
            endcase
        end

        if (emit) begin
            valid_d   = 1'b1;
            msg_cnt_d = msg_cnt_q + 32'd1;
        end
        if (drop) begin
            err_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_TYPE;
            idx_q       <= 2'd0;
            out_price_q <= 32'd0;
            out_qty_q   <= 32'd0;
            out_buy_q   <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            msg_cnt_q   <= 32'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_price_q <= out_price_d;
            out_qty_q   <= out_qty_d;
            out_buy_q   <= out_buy_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            msg_cnt_q   <= msg_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Field assembly registers are only meaningful once the FSM has walked past them.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        price_q <= price_d;
        side_q  <= side_d;
`ifdef TICK_PARSER_CHECKSUM_EN
        csum_q  <= csum_d;
`endif
    end

    assign m_tick_price  = out_price_q;
    assign m_tick_qty    = out_qty_q;
    assign m_tick_is_buy = out_buy_q;
    assign m_tick_valid  = valid_q;
    assign err_pulse     = err_q;
    assign msg_count     = msg_cnt_q;
    assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_tick_msg_parser.sv
// Scoreboard bench for tick_msg_parser; covers both builds (TICK_PARSER_CHECKSUM_EN).
module tb_tick_msg_parser;
    import tick_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_tick_price;
    logic [31:0] m_tick_qty;
    logic        m_tick_is_buy;
    logic        m_tick_valid;
    logic        err_pulse;
    logic [31:0] msg_count;
    logic [15:0] drop_count;

    typedef struct packed {
        logic [31:0] price;
        logic [31:0] qty;
        logic        is_buy;
    } tick_t;

    tick_t       exp_q[$];
    logic [7:0]  frm[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_drops = 0;
    int          exp_msgs = 0;
    int          err_seen = 0;

    tick_msg_parser dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_tick_price  (m_tick_price),
        .m_tick_qty    (m_tick_qty),
        .m_tick_is_buy (m_tick_is_buy),
        .m_tick_valid  (m_tick_valid),
        .err_pulse     (err_pulse),
        .msg_count     (msg_count),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Passive monitor: sample outputs mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        check_eq("tready", {31'd0, s_axis_tready}, {31'd0, ~rst});
        if (!rst && err_pulse) err_seen++;
        if (!rst && m_tick_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_tick", 32'd1, 32'd0);
            end else begin
                tick_t e;
                e = exp_q.pop_front();
                exp_msgs++;
                check_eq("price", m_tick_price, e.price);
                check_eq("qty", m_tick_qty, e.qty);
                check_eq("is_buy", {31'd0, m_tick_is_buy}, {31'd0, e.is_buy});
                check_eq("msg_count", msg_count, exp_msgs);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic l);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Builds a datagram: cut shortens it below the full message, trail appends filler.
    task automatic frame(input logic [7:0] typ, input logic [7:0] side,
                         input logic [31:0] price, input logic [31:0] qty,
                         input int cut, input int trail, input bit bad_csum);
        logic [7:0] x;
        int         len;
        bit         ok;
        frm.delete();
        frm.push_back(typ);
        frm.push_back(side);
        for (int i = 3; i >= 0; i--) frm.push_back(price[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) frm.push_back(qty[i*8 +: 8]);
        if (MSG_LEN == 11) begin
            x = 8'h00;
            foreach (frm[i]) x = x ^ frm[i];
            frm.push_back(bad_csum ? (x ^ 8'h04) : x);
        end
        len = (cut > 0) ? cut : MSG_LEN;
        while (frm.size() > len) void'(frm.pop_back());
        for (int i = 0; i < trail; i++) frm.push_back(8'h00);
        ok = (len == MSG_LEN) && (typ == 8'h41) && (side == 8'h42 || side == 8'h53)
             && (price != 32'd0) && !(bad_csum && MSG_LEN == 11);
        if (ok) exp_q.push_back('{price: price, qty: qty, is_buy: (side == 8'h42)});
        else    exp_drops++;
        for (int i = 0; i < frm.size(); i++) send_byte(frm[i], i == frm.size() - 1);
    endtask

    task automatic settle_and_check(input string tag);
        idle(3);
        check_eq({tag, "_drops"}, {16'd0, drop_count}, exp_drops);
        check_eq({tag, "_errs"}, err_seen, exp_drops);
        check_eq({tag, "_pending"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", {31'd0, m_tick_valid}, 32'd0);
        check_eq("rst_err", {31'd0, err_pulse}, 32'd0);
        check_eq("rst_price", m_tick_price, 32'd0);
        check_eq("rst_msgs", msg_count, 32'd0);
        check_eq("rst_drops", {16'd0, drop_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        frame(8'h41, 8'h42, 32'd15000, 32'd100, 0, 0, 1'b0);
        settle_and_check("basic");

        frame(8'h41, 8'h53, 32'd15001, 32'd10, 0, 2, 1'b0);
        frame(8'h41, 8'h42, 32'd7, 32'h01020304, 0, 0, 1'b0);
        settle_and_check("trailing");

        frame(8'h41, 8'h42, 32'd15000, 32'd100, 4, 0, 1'b0);
        frame(8'h41, 8'h53, 32'd99, 32'd5, 0, 0, 1'b0);
        settle_and_check("short");

        frame(8'h58, 8'h42, 32'd100, 32'd1, 0, 0, 1'b0);
        frame(8'h41, 8'h51, 32'd100, 32'd1, 0, 0, 1'b0);
        frame(8'h41, 8'h42, 32'd0, 32'd1, 0, 0, 1'b0);
        frame(8'h41, 8'h42, 32'd1, 32'd1, MSG_LEN - 1, 0, 1'b0);
        settle_and_check("drops");

        for (int i = 0; i < 6; i++)
            frame(8'h41, (i % 2) ? 8'h53 : 8'h42, $urandom_range(1, 32'hFFFF_FFFF),
                  $urandom, 0, i % 3, 1'b0);
        settle_and_check("b2b");

        if (MSG_LEN == 11) begin
            frame(8'h41, 8'h42, 32'd1234, 32'd55, 0, 0, 1'b1);
            frame(8'h41, 8'h53, 32'd4321, 32'd66, 0, 0, 1'b0);
            settle_and_check("csum");
        end

        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_drops = 0;
        exp_msgs  = 0;
        err_seen  = 0;
        check_eq("midrst_msgs", msg_count, 32'd0);
        check_eq("midrst_drops", {16'd0, drop_count}, 32'd0);
        rst = 1'b0;
        idle(1);
        frame(8'h41, 8'h53, 32'd500, 32'd9, 0, 0, 1'b0);
        settle_and_check("after_rst");
        check_eq("after_rst_msgs", msg_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tick_msg_parser.md
TICK_MSG_PARSER -- requirements
Module: tick_msg_parser

Interface
REQ-001 clk  in  1  sole clock; all logic rising-edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 s_axis_tdata  in  8  UDP payload byte stream.
REQ-004 s_axis_tvalid  in  1  byte qualifier.
REQ-005 s_axis_tlast  in  1  marks last payload byte of a datagram.
REQ-006 s_axis_tready  out  1  byte accept; transfer occurs when tvalid and tready are both 1.
REQ-007 m_tick_price  out  32  decoded price, integer cents.
REQ-008 m_tick_qty  out  32  decoded quantity.
REQ-009 m_tick_is_buy  out  1  1 = bid, 0 = ask.
REQ-010 m_tick_valid  out  1  one-cycle pulse qualifying m_tick_* (no backpressure).
REQ-011 err_pulse  out  1  one-cycle pulse on any dropped message.
REQ-012 msg_count  out  32  count of ticks emitted, wraps.
REQ-013 drop_count  out  16  count of dropped messages, saturates at 0xFFFF.

Function
REQ-014 Message format SHALL be: byte0 type, byte1 side, bytes2-5 price big-endian, bytes6-9 qty big-endian; one message per datagram.
REQ-015 Only type 0x41 ('A') SHALL be decoded; any other type SHALL be dropped.
REQ-016 Side 0x42 ('B') SHALL map to is_buy=1, 0x53 ('S') to is_buy=0; any other value SHALL drop the message.
REQ-017 FSM states SHALL be TYPE, SIDE, PRICE, QTY, CSUM (macro only), SKIP; a 2-bit byte index SHALL sequence the PRICE and QTY states.
REQ-018 TYPE->SIDE on a valid type; SIDE->PRICE; PRICE->QTY after 4 bytes; QTY->TYPE (or CSUM) after 4 bytes; any drop condition->SKIP; SKIP->TYPE on a tlast beat.
REQ-019 m_tick_valid SHALL assert the cycle after the final message byte is accepted (latency 1), with m_tick_* stable in that cycle and held until the next emit.
REQ-020 A price of 0 SHALL be dropped and SHALL NOT emit a tick.
REQ-021 tlast before the final message byte SHALL drop the message; the FSM SHALL return to TYPE on the next cycle without entering SKIP.
REQ-022 Bytes after the final message byte, up to and including tlast, SHALL be ignored via SKIP; the tick SHALL still be emitted.
REQ-023 If the final message byte also carries tlast, the FSM SHALL go directly to TYPE.
REQ-024 Every drop SHALL pulse err_pulse once, in the cycle after the offending byte, and SHALL increment drop_count once.
REQ-025 s_axis_tready SHALL be 1 in every cycle except during reset, allowing full-rate back-to-back datagrams.
REQ-026 msg_count SHALL increment in the same cycle that m_tick_valid is 1.

Reset
REQ-027 When rst=1: state=TYPE; m_tick_* = 0; err_pulse = 0; both counters = 0; s_axis_tready = 0.
REQ-028 Reset asserted mid-message SHALL discard the partial message with no emit and no drop count.

Configuration
REQ-029 With TICK_PARSER_CHECKSUM_EN defined, byte 10 SHALL equal the XOR of bytes 0-9; on mismatch the message SHALL be dropped; tlast on byte 9 counts as short; the tick SHALL emit the cycle after byte 10.
REQ-030 Without TICK_PARSER_CHECKSUM_EN, the message SHALL be 10 bytes, and no CSUM state or XOR logic SHALL exist.

Structure
REQ-031 A shared package tick_pkg SHALL hold the FSM state enum, the MSG_TYPE_ADD, SIDE_BUY and SIDE_SELL constants, and the MSG_LEN constant.
REQ-032 The design SHALL be a single module with no sub-modules; field assembly SHALL use a shift-in register.

Verification
REQ-033 Send 41 42 00 00 3A 98 00 00 00 64 with tlast -> one pulse: price=15000, qty=100, is_buy=1, msg_count=1.
REQ-034 Send 41 53 00 00 3A 99 00 00 00 0A 00 00 with tlast on the last 00 -> tick price=15001, is_buy=0; trailing bytes ignored; next datagram decodes normally.
REQ-035 Send 41 42 00 00 with tlast -> no tick; err_pulse=1 once; drop_count=1; the following valid datagram emits.
REQ-036 Send type 0x58, side 0x51, and price 0 cases -> three drops, drop_count=3, no tick.
REQ-037 Back-to-back valid datagrams with no idle cycles -> one tick per datagram; tready remains 1.
REQ-038 CHECKSUM_EN: correct XOR byte -> tick; flipped bit -> drop, err_pulse; rst asserted mid-message -> no output, counters 0.
